// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one-outstanding imem requests and
// presents fetched instructions to decode. Define FETCH_CTRL_PERF_EN to add stall/flush counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      r_state, w_state_next, w_resume_state;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_inflight_pc, w_inflight_pc_next;
  logic [31:0] r_instr, w_instr_next;
  logic [31:0] r_instr_pc, w_instr_pc_next;
  logic        r_kill, w_kill_next;
  logic        w_discard;
  logic [31:0] w_redirect_pc;

  assign w_redirect_pc  = {redirect_pc_i[31:2], 2'b00};
  assign w_resume_state = fetch_en_i ? StReq : StIdle;

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_inflight_pc_next = r_inflight_pc;
    w_instr_next       = r_instr;
    w_instr_pc_next    = r_instr_pc;
    w_kill_next        = r_kill;
    w_discard          = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!redirect_i && fetch_en_i) w_state_next = StReq;
      end
      StReq: begin
        if (imem_gnt_i) begin
          w_state_next       = StWait;
          w_kill_next        = redirect_i;
          w_inflight_pc_next = r_pc;
        end
      end
      StWait: begin
        if (imem_rvalid_i) begin
          w_kill_next = 1'b0;
          if (redirect_i || r_kill) begin
            w_discard    = 1'b1;
            w_state_next = w_resume_state;
          end else begin
            w_instr_next    = imem_rdata_i;
            w_instr_pc_next = r_inflight_pc;
            w_pc_next       = r_inflight_pc + 32'd4;
            w_state_next    = StHold;
          end
        end else if (redirect_i) begin
          w_kill_next = 1'b1;
        end
      end
      StHold: begin
        // A redirect voids any coinciding handshake; decode flushes on the same redirect.
        if (redirect_i || instr_ready_i) begin
          w_instr_next = NOP_INSTR;
          w_discard    = redirect_i;
          w_state_next = w_resume_state;
        end
      end
      default: w_state_next = StIdle;
    endcase
    if (redirect_i) w_pc_next = w_redirect_pc;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= StIdle;
      r_pc          <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= RESET_PC;
      r_kill        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_inflight_pc <= w_inflight_pc_next;
      r_instr       <= w_instr_next;
      r_instr_pc    <= w_instr_pc_next;
      r_kill        <= w_kill_next;
    end
  end

  assign imem_req_o    = (r_state == StReq);
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = (r_state == StHold);
  assign instr_o       = r_instr;
  assign pc_o          = r_instr_pc;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if ((r_state == StHold) && !instr_ready_i) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_discard) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = r_stall_cnt;
  assign perf_flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scenarios followed by randomized traffic checked against a transaction-level model.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        fetch_en_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        instr_ready_i = 1'b0;

  logic        imem_req_o, instr_valid_o;
  logic [31:0] imem_addr_o, instr_o, pc_o;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, w_stall_cnt, w_flush_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  fetch_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .fetch_en_i    (fetch_en_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_cnt_o (stall_cnt),
    .perf_flush_cnt_o (flush_cnt)
`endif
  );

  // Same stimulus, wrapping reset PC.
  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .fetch_en_i    (fetch_en_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (w_req),
    .imem_addr_o   (w_addr),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (w_valid),
    .instr_ready_i (instr_ready_i),
    .instr_o       (w_instr),
    .pc_o          (w_pc)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_cnt_o (w_stall_cnt),
    .perf_flush_cnt_o (w_flush_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference model state
  logic [31:0] m_pc, m_busy_pc, m_held_instr, m_shown_pc, m_stall, m_flush;
  logic        m_req, m_busy, m_stale, m_held, restart;

  initial begin
    #3 rst_i = 1'b1;
    tick();
    tick();
    check("rst_req", imem_req_o, 1'b0);
    check("rst_addr", imem_addr_o, 32'h8000_0000);
    check("rst_valid", instr_valid_o, 1'b0);
    check("rst_instr", instr_o, NOP);
    check("rst_pc", pc_o, 32'h8000_0000);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

    // Zero-wait fetch
    rst_i = 1'b0;
    fetch_en_i = 1'b1;
    tick();
    check("t1_req", imem_req_o, 1'b1);
    check("t1_addr", imem_addr_o, 32'h8000_0000);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    check("t1_wait_req", imem_req_o, 1'b0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h0010_0093;
    tick();
    imem_rvalid_i = 1'b0;
    check("t1_valid", instr_valid_o, 1'b1);
    check("t1_pc", pc_o, 32'h8000_0000);
    check("t1_instr", instr_o, 32'h0010_0093);
    check("t6_wrap_pc", w_pc, 32'hFFFF_FFFC);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    check("t1_valid_drop", instr_valid_o, 1'b0);
    check("t1_nop", instr_o, NOP);
    check("t1_next_addr", imem_addr_o, 32'h8000_0004);
    check("t6_wrap_addr", w_addr, 32'h0000_0000);

    // Grant delayed 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_req_hold", imem_req_o, 1'b1);
      check("t2_addr_hold", imem_addr_o, 32'h8000_0004);
    end
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    tick();
    check("t2_no_valid", instr_valid_o, 1'b0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h0020_0113;
    tick();
    imem_rvalid_i = 1'b0;
    check("t2_valid", instr_valid_o, 1'b1);

    // Decode stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      check("t4_valid", instr_valid_o, 1'b1);
      check("t4_instr", instr_o, 32'h0020_0113);
      check("t4_pc", pc_o, 32'h8000_0004);
      tick();
    end
`ifdef FETCH_CTRL_PERF_EN
    check("t4_stall_cnt", stall_cnt, 32'd5);
`endif
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    check("t4_valid_drop", instr_valid_o, 1'b0);
    check("t4_next_addr", imem_addr_o, 32'h8000_0008);

    // Redirect during WAIT, stale response discarded
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0102;
    tick();
    redirect_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    check("t3_no_valid", instr_valid_o, 1'b0);
    tick();
    imem_rvalid_i = 1'b0;
    check("t3_discard_valid", instr_valid_o, 1'b0);
    check("t3_discard_instr", instr_o, NOP);
    check("t3_req", imem_req_o, 1'b1);
    check("t3_addr", imem_addr_o, 32'h8000_0100);
`ifdef FETCH_CTRL_PERF_EN
    check("t3_flush_cnt", flush_cnt, 32'd1);
`endif

    // Redirect coinciding with grant
    imem_gnt_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0200;
    tick();
    imem_gnt_i = 1'b0;
    redirect_i = 1'b0;
    check("t5_wait_req", imem_req_o, 1'b0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    check("t5_no_valid", instr_valid_o, 1'b0);
    check("t5_req", imem_req_o, 1'b1);
    check("t5_addr", imem_addr_o, 32'h8000_0200);
`ifdef FETCH_CTRL_PERF_EN
    check("t5_flush_cnt", flush_cnt, 32'd2);
`endif

    // Asynchronous reset during WAIT; late rvalid ignored
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("t6_rst_req", imem_req_o, 1'b0);
    check("t6_rst_addr", imem_addr_o, 32'h8000_0000);
    check("t6_rst_valid", instr_valid_o, 1'b0);
    check("t6_rst_instr", instr_o, NOP);
    check("t6_rst_pc", pc_o, 32'h8000_0000);
    fetch_en_i = 1'b0;
    imem_rvalid_i = 1'b1;
    #1 rst_i = 1'b0;
    tick();
    tick();
    imem_rvalid_i = 1'b0;
    check("t6_late_valid", instr_valid_o, 1'b0);
    check("t6_late_req", imem_req_o, 1'b0);
    check("t6_late_instr", instr_o, NOP);

    // Randomized traffic against the model
    m_pc = 32'h8000_0000;
    m_busy_pc = 32'd0;
    m_held_instr = 32'd0;
    m_shown_pc = 32'h8000_0000;
    m_stall = 32'd0;
    m_flush = 32'd0;
    m_req = 1'b0;
    m_busy = 1'b0;
    m_stale = 1'b0;
    m_held = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      check("rnd_req", imem_req_o, m_req);
      check("rnd_addr", imem_addr_o, m_pc);
      check("rnd_valid", instr_valid_o, m_held);
      check("rnd_instr", instr_o, m_held ? m_held_instr : NOP);
      check("rnd_pc", pc_o, m_shown_pc);
`ifdef FETCH_CTRL_PERF_EN
      check("rnd_stall_cnt", stall_cnt, m_stall);
      check("rnd_flush_cnt", flush_cnt, m_flush);
`endif
      fetch_en_i = ($urandom_range(0, 7) != 0);
      redirect_i = ($urandom_range(0, 9) == 0);
      redirect_pc_i = $urandom;
      imem_gnt_i = $urandom_range(0, 1) == 1;
      imem_rvalid_i = $urandom_range(0, 1) == 1;
      imem_rdata_i = $urandom;
      instr_ready_i = $urandom_range(0, 1) == 1;

      restart = 1'b0;
      if (m_held && !instr_ready_i) m_stall = m_stall + 32'd1;
      if (redirect_i) begin
        if (m_req) begin
          if (imem_gnt_i) begin
            m_req = 1'b0;
            m_busy = 1'b1;
            m_stale = 1'b1;
          end
        end else if (m_busy) begin
          if (imem_rvalid_i) begin
            m_busy = 1'b0;
            m_flush = m_flush + 32'd1;
            restart = 1'b1;
          end else begin
            m_stale = 1'b1;
          end
        end else if (m_held) begin
          m_held = 1'b0;
          m_flush = m_flush + 32'd1;
          restart = 1'b1;
        end
        m_pc = redirect_pc_i & 32'hFFFF_FFFC;
      end else if (m_req) begin
        if (imem_gnt_i) begin
          m_req = 1'b0;
          m_busy = 1'b1;
          m_stale = 1'b0;
          m_busy_pc = m_pc;
        end
      end else if (m_busy) begin
        if (imem_rvalid_i) begin
          m_busy = 1'b0;
          if (m_stale) begin
            m_flush = m_flush + 32'd1;
            restart = 1'b1;
          end else begin
            m_held = 1'b1;
            m_held_instr = imem_rdata_i;
            m_shown_pc = m_busy_pc;
            m_pc = m_busy_pc + 32'd4;
          end
        end
      end else if (m_held) begin
        if (instr_ready_i) begin
          m_held = 1'b0;
          restart = 1'b1;
        end
      end else if (fetch_en_i) begin
        m_req = 1'b1;
      end
      if (restart) m_req = fetch_en_i;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
